wb_matmul_engine: RTL and testbench
===================================

Name: wb_matmul_engine

Overview:
- Wishbone-slave matrix-multiply core instantiated inside the user project, directly downstream of the Caravel management-SoC Wishbone port.
- Firmware writes NxN matrices A and B, then issues START.
- The core computes C = A x B with one multiply-accumulate per cycle and raises a done interrupt.
- Firmware then reads C back over the same bus.

Parameters:
- N, 4, matrix dimension; legal range 2..8 (N*N <= 64 words per bank).
- DW, 8, element width in bits.
- BASE_ADR, 32'h3000_0000, bus base address; only wbs_adr_i[31:12] is compared against BASE_ADR[31:12].

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_n_i  in  1  synchronous, active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; only bit 0 is used.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- irq_o  out  1  done interrupt, level.
- busy_o  out  1  high while computing.

Behaviour:
- Clock and reset: single clock wb_clk_i. Reset wb_rst_n_i is synchronous and active-low.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, busy_o=0. FSM=IDLE. Counters i/j/k=0, accumulator=0. All A/B/C storage cleared to 0.
- Address map (offset = wbs_adr_i[11:0]; element index = offset[7:2], row-major, idx = row*N + col):
  - 0x000-0x0FC: A[idx], W/R, DW bits, upper bits read 0.
  - 0x100-0x1FC: B[idx], W/R.
  - 0x200-0x2FC: C[idx], RO, CW = 2*DW + clog2(N) bits, zero-extended to 32.
  - 0x300 CTRL: write bit0=1 -> START (self-clearing, reads 0).
  - 0x304 STATUS: bit0=busy, bit1=done. Writing 1 to bit1 clears done.
  - Indices >= N*N and all other offsets: write ignored, read returns 0, still acked.
- Handshake:
  - Request = wbs_cyc_i & wbs_stb_i & address match.
  - wbs_ack_o is registered: asserted exactly 1 cycle after request, held for 1 cycle.
  - No ack in the cycle following an ack, so back-to-back requests see 1 idle cycle.
  - Read data is valid in the ack cycle.
  - A non-matching address is never acked.
- Element writes take effect only when wbs_sel_i[0]=1; wbs_dat_i[DW-1:0] is stored.
- FSM IDLE -> CALC -> DONE -> IDLE:
  - IDLE: START write -> CALC at the ack edge. Clear i/j/k and the accumulator. Clear the done flag.
  - CALC: each cycle, acc_next = (k==0 ? 0 : acc) + A[i*N+k]*B[k*N+j].
    - When k==N-1, write acc_next into C[i*N+j].
    - k increments and wraps to 0 after N-1, then j increments; j wraps, then i increments.
    - After i=j=k=N-1 -> DONE.
    - busy_o=1 for exactly N^3 cycles.
  - DONE: one cycle. Set done flag (irq_o = done), busy_o=0 -> IDLE.
- Arithmetic: unsigned. CW is sized so the result cannot overflow.
- Simultaneous events and boundary cases:
  - A/B writes while busy: acked, no effect.
  - START while busy: ignored.
  - C reads while busy: return the current (partial/stale) contents.
  - Done-clear write in the same cycle that DONE sets it: set wins.
  - irq_o remains high until cleared, or until a new START.
  - Reset mid-CALC: the FSM aborts to IDLE on the next edge and all storage is cleared.

Optional Feature:
- Macro: MATMUL_SIGNED_EN.
- Defined:
  - Elements are two's-complement.
  - The product is signed.
  - C is sign-extended to 32 bits on read.
  - A/B reads sign-extend DW to 32.
- Undefined: all of the above is unsigned with zero-extension, as specified in Behaviour.

Test Plan:
- Reset check: drive wb_rst_n_i=0 for 3 cycles, release, then read 0x304, 0x000 and 0x200 -> each acked 1 cycle after stb, data 0. irq_o=0, busy_o=0.
- Basic multiply (N=2): write A={1,2,3,4}, B={5,6,7,8}, then write 0x300=1.
  - busy_o high for exactly 8 cycles, then irq_o=1.
  - C reads 19, 22, 43, 50.
  - STATUS=0x2. After writing 0x304=0x2, STATUS=0 and irq_o=0.
- Extremes (N=4, DW=8): all A=B=255 -> every C word = 260100 (0x3F804). Under MATMUL_SIGNED_EN with all A=B=-1 -> every C word = 4.
- Busy protection: while busy, write A[0]=9 and a second START -> both acked. Results match the original A, and busy lasts only N^3 cycles total.
- Bus edges:
  - Read at 0x0F0 with N=4 (idx 60) -> 0, acked.
  - Request with adr=0x4000_0000 -> no ack.
  - Write with wbs_sel_i=0 -> element unchanged.
  - Back-to-back stb -> 1 idle cycle between acks.
- Reset mid-CALC: assert reset at cycle 5 of CALC -> next edge busy_o=0, irq_o=0, all C reads 0, and a fresh START completes correctly.

Source files
------------

// File: rtl/wb_matmul_engine_if.sv
// Wishbone slave bundle for wb_matmul_engine.
// Master drives stb/cyc/we/sel/adr/dat_i; slave returns ack/dat_o.
interface wb_matmul_engine_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_matmul_engine.sv
// Wishbone matrix-multiply core: C = A x B, one MAC per cycle.
// Ports: wb_clk_i, wb_rst_n_i (sync, active-low), wbs (slave
// bus: A @0x000, B @0x100, C @0x200, CTRL @0x300, STATUS @0x304),
// irq_o (done level), busy_o (computing).
// Option: define MATMUL_SIGNED_EN for two's-complement elements.
module wb_matmul_engine #(
  parameter int          N        = 4,
  parameter int          DW       = 8,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  wb_matmul_engine_if.slave wbs,
  output logic              irq_o,
  output logic              busy_o
);
  localparam int NN = N * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = $clog2(NN);
  localparam int CW = 2 * DW + $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] k_q, k_d;
  logic [CW-1:0] acc_q, acc_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [DW-1:0] a_q [NN];
  logic [DW-1:0] a_d [NN];
  logic [DW-1:0] b_q [NN];
  logic [DW-1:0] b_d [NN];
  logic [CW-1:0] c_q [NN];
  logic [CW-1:0] c_d [NN];

  logic          req, go, wr;
  logic [11:0]   ofs;
  logic [5:0]    eidx;
  logic [XW-1:0] bidx;
  logic          idx_ok;
  logic          sel_a, sel_b, sel_c;
  logic          hit_ctrl, hit_stat;
  logic          start, clr_done;
  logic [31:0]   rd_val;
  logic [XW-1:0] a_ix, b_ix, c_ix;
  logic [DW-1:0] a_op, b_op;
  logic [CW-1:0] prod, acc_nx;
  logic          unused_bits;

  function automatic logic [31:0] ext_e(input logic [DW-1:0] v);
`ifdef MATMUL_SIGNED_EN
    return 32'($signed(v));
`else
    return 32'(v);
`endif
  endfunction

  function automatic logic [31:0] ext_c(input logic [CW-1:0] v);
`ifdef MATMUL_SIGNED_EN
    return 32'($signed(v));
`else
    return 32'(v);
`endif
  endfunction

  assign unused_bits = ^{wbs.wbs_sel_i[3:1],
                         wbs.wbs_adr_i[1:0],
                         wbs.wbs_dat_i[31:DW]};

  // Bus decode; ack is registered and never issued twice in a row.
  always_comb begin
    req = wbs.wbs_cyc_i & wbs.wbs_stb_i &
          (wbs.wbs_adr_i[31:12] == BASE_ADR[31:12]);
    go       = req & ~ack_q;
    wr       = go & wbs.wbs_we_i;
    ofs      = wbs.wbs_adr_i[11:0];
    eidx     = ofs[7:2];
    bidx     = XW'(eidx);
    idx_ok   = ({26'd0, eidx} < 32'(NN));
    sel_a    = (ofs[11:8] == 4'h0) & idx_ok;
    sel_b    = (ofs[11:8] == 4'h1) & idx_ok;
    sel_c    = (ofs[11:8] == 4'h2) & idx_ok;
    hit_ctrl = (ofs[11:2] == 10'h0C0);
    hit_stat = (ofs[11:2] == 10'h0C1);
    start    = wr & hit_ctrl & wbs.wbs_dat_i[0];
    clr_done = wr & hit_stat & wbs.wbs_dat_i[1];
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_a:    rd_val = ext_e(a_q[bidx]);
      sel_b:    rd_val = ext_e(b_q[bidx]);
      sel_c:    rd_val = ext_c(c_q[bidx]);
      hit_stat: rd_val = {30'd0, done_q, state_q == S_CALC};
      default:  rd_val = '0;
    endcase
  end

  // Datapath for the current MAC step.
  always_comb begin
    a_ix = XW'(int'(i_q) * N + int'(k_q));
    b_ix = XW'(int'(k_q) * N + int'(j_q));
    c_ix = XW'(int'(i_q) * N + int'(j_q));
    a_op = a_q[a_ix];
    b_op = b_q[b_ix];
`ifdef MATMUL_SIGNED_EN
    prod = CW'($signed(a_op)) * CW'($signed(b_op));
`else
    prod = CW'(a_op) * CW'(b_op);
`endif
    acc_nx = ((k_q == '0) ? '0 : acc_q) + prod;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    done_d  = done_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    ack_d   = go;
    dat_d   = go ? rd_val : '0;

    if (clr_done) done_d = 1'b0;

    if (state_q == S_IDLE && wr && wbs.wbs_sel_i[0]) begin
      if (sel_a) a_d[bidx] = wbs.wbs_dat_i[DW-1:0];
      if (sel_b) b_d[bidx] = wbs.wbs_dat_i[DW-1:0];
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          done_d  = 1'b0;
        end
      end
      S_CALC: begin
        acc_d = acc_nx;
        if (k_q == LAST) begin
          c_d[c_ix] = acc_nx;
          k_d = '0;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) state_d = S_DONE;
            else i_d = i_q + IW'(1);
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_DONE: begin
        // Setting has priority over a same-cycle clear.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      for (int n = 0; n < NN; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign irq_o         = done_q;
  assign busy_o        = (state_q == S_CALC);
endmodule

// File: tb/tb_wb_matmul_engine.sv
// Directed bench for wb_matmul_engine (N=2 and N=4 instances).
// Bus stimulus is shared; dsel picks which instance sees cyc.
module tb_wb_matmul_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  int          dsel = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  wb_matmul_engine_if bus2 ();
  wb_matmul_engine_if bus4 ();

  assign bus2.wbs_cyc_i = cyc & (dsel == 0);
  assign bus2.wbs_stb_i = stb;
  assign bus2.wbs_we_i  = we;
  assign bus2.wbs_sel_i = sel;
  assign bus2.wbs_adr_i = adr;
  assign bus2.wbs_dat_i = wdat;
  assign bus4.wbs_cyc_i = cyc & (dsel == 1);
  assign bus4.wbs_stb_i = stb;
  assign bus4.wbs_we_i  = we;
  assign bus4.wbs_sel_i = sel;
  assign bus4.wbs_adr_i = adr;
  assign bus4.wbs_dat_i = wdat;

  logic irq2, busy2, irq4, busy4;
  logic ack;
  logic [31:0] rdat;

  assign ack  = (dsel == 0) ? bus2.wbs_ack_o : bus4.wbs_ack_o;
  assign rdat = (dsel == 0) ? bus2.wbs_dat_o : bus4.wbs_dat_o;

  wb_matmul_engine #(.N(2), .DW(8)) u2 (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs        (bus2.slave),
    .irq_o      (irq2),
    .busy_o     (busy2)
  );

  wb_matmul_engine #(.N(4), .DW(8)) u4 (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs        (bus4.slave),
    .irq_o      (irq4),
    .busy_o     (busy4)
  );

`ifdef MATMUL_SIGNED_EN
  localparam logic [31:0] C_EXT = 32'd4;
  localparam logic [31:0] A_FF  = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] C_EXT = 32'd260100;
  localparam logic [31:0] A_FF  = 32'h0000_00FF;
`endif
  localparam logic [31:0] BA = 32'h3000_0000;

  // Length of the most recent busy run of each instance.
  int run2 = 0, len2 = 0, run4 = 0, len4 = 0;
  always @(posedge clk) begin
    if (busy2) run2 <= run2 + 1;
    else if (run2 != 0) begin
      len2 <= run2;
      run2 <= 0;
    end
    if (busy4) run4 <= run4 + 1;
    else if (run4 != 0) begin
      len4 <= run4;
      run4 <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r, output int lat);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = -1;
    r = '0;
    for (int c = 1; c <= 4 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = c;
        r = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int lat;
    xfer(1'b1, a, d, 4'h1, r, lat);
    chk($sformatf("wr_ack_%0h", a), 32'(lat), 32'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    logic [31:0] r;
    int lat;
    xfer(1'b0, a, '0, 4'h1, r, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk(tag, r, exp);
  endtask

  task automatic wait_irq(input string tag);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(posedge clk); #1;
      got = (dsel == 0) ? irq2 : irq4;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [5:0]  pat;
    int          lat;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    dsel = 1;
    chk("rst_irq4", 32'(irq4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_irq2", 32'(irq2), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_dat", bus4.wbs_dat_o, 32'd0);
    rd("rst_status", BA + 32'h304, 32'd0);
    rd("rst_a0", BA + 32'h000, 32'd0);
    rd("rst_c0", BA + 32'h200, 32'd0);

    // Basic 2x2 multiply
    dsel = 0;
    for (int n = 0; n < 4; n++) begin
      wr(BA + 32'(4 * n), 32'(n + 1));
      wr(BA + 32'h100 + 32'(4 * n), 32'(n + 5));
    end
    rd("n2_a3", BA + 32'h00C, 32'd4);
    wr(BA + 32'h300, 32'd1);
    wait_irq("n2_irq");
    chk("n2_busy_len", 32'(len2), 32'd8);
    chk("n2_busy_off", 32'(busy2), 32'd0);
    rd("n2_c0", BA + 32'h200, 32'd19);
    rd("n2_c1", BA + 32'h204, 32'd22);
    rd("n2_c2", BA + 32'h208, 32'd43);
    rd("n2_c3", BA + 32'h20C, 32'd50);
    rd("n2_status", BA + 32'h304, 32'h2);
    wr(BA + 32'h304, 32'h2);
    rd("n2_status_clr", BA + 32'h304, 32'h0);
    chk("n2_irq_clr", 32'(irq2), 32'd0);

    // Extremes 4x4, all elements 0xFF
    dsel = 1;
    for (int n = 0; n < 16; n++) begin
      wr(BA + 32'(4 * n), 32'hFF);
      wr(BA + 32'h100 + 32'(4 * n), 32'hFF);
    end
    rd("n4_a0_ext", BA + 32'h000, A_FF);
    wr(BA + 32'h300, 32'd1);
    wait_irq("n4_irq");
    chk("n4_busy_len", 32'(len4), 32'd64);
    for (int n = 0; n < 16; n++)
      rd($sformatf("n4_c%0d", n), BA + 32'h200 + 32'(4 * n), C_EXT);

    // New START clears irq; writes and START while busy ignored
    wr(BA + 32'h300, 32'd1);
    chk("restart_irq_clr", 32'(irq4), 32'd0);
    chk("restart_busy", 32'(busy4), 32'd1);
    wr(BA + 32'h000, 32'd9);
    wr(BA + 32'h300, 32'd1);
    rd("busy_status", BA + 32'h304, 32'h1);
    wait_irq("prot_irq");
    chk("prot_busy_len", 32'(len4), 32'd64);
    rd("prot_a0", BA + 32'h000, A_FF);
    rd("prot_c0", BA + 32'h200, C_EXT);
    rd("prot_c15", BA + 32'h23C, C_EXT);

    // Bus edges
    rd("idx60", BA + 32'h0F0, 32'd0);
    rd("bad_off", BA + 32'h400, 32'd0);
    xfer(1'b0, 32'h4000_0000, '0, 4'h1, r, lat);
    chk("no_match_ack", 32'(lat), 32'hFFFF_FFFF);
    xfer(1'b1, BA + 32'h004, 32'h12, 4'h0, r, lat);
    chk("sel0_ack", 32'(lat), 32'd1);
    rd("sel0_a1", BA + 32'h004, A_FF);
    wr(BA + 32'h004, 32'h12);
    rd("sel1_a1", BA + 32'h004, 32'h12);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BA + 32'h004;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      pat[c] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("b2b_pattern", 32'(pat), 32'h15);

    // Reset during CALC
    wr(BA + 32'h300, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy4), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy4), 32'd0);
    chk("mid_rst_irq", 32'(irq4), 32'd0);
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++)
      rd($sformatf("mid_c%0d", n), BA + 32'h200 + 32'(4 * n), 32'd0);
    rd("mid_a0", BA + 32'h000, 32'd0);

    // Fresh run: A = 2*I, B[idx] = idx -> C[idx] = 2*idx
    for (int n = 0; n < 16; n++) begin
      if (n % 5 == 0) wr(BA + 32'(4 * n), 32'd2);
      wr(BA + 32'h100 + 32'(4 * n), 32'(n));
    end
    wr(BA + 32'h300, 32'd1);
    wait_irq("fresh_irq");
    chk("fresh_busy_len", 32'(len4), 32'd64);
    for (int n = 0; n < 16; n++)
      rd($sformatf("fresh_c%0d", n), BA + 32'h200 + 32'(4 * n),
         32'(2 * n));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
